// File: rtl/fifo_byte_packetizer.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_byte_packetizer
//  Description : Pulls 32-bit words from a valid/ready FIFO and emits framed
//                byte packets: SYNC, LEN, PKT_WORDS*4 payload bytes (each
//                word LSB first), then an XOR checksum over LEN and payload.
//                Valid/ready backpressure on both sides.
//  Ports       : sys_clk, sys_rst       - clock, synchronous active-high reset
//                RX_Data/Valid/Ready    - word input from FIFO TX side
//                TX_Data/Valid/Ready    - registered byte output
//                busy                   - high whenever not IDLE
//                pkt_count              - completed packet counter (wraps)
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_byte_packetizer #(
    parameter logic [7:0]  SYNC      = 8'hA5,
    parameter int unsigned PKT_WORDS = 8
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [31:0] RX_Data,
    input  logic        RX_Valid,
    output logic        RX_Ready,
    output logic [7:0]  TX_Data,
    output logic        TX_Valid,
    input  logic        TX_Ready,
    output logic        busy,
    output logic [15:0] pkt_count
);

    localparam logic [7:0] c_LEN   = 8'(PKT_WORDS * 4);
    localparam logic [6:0] c_WORDS = 7'(PKT_WORDS);

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_HDR     = 3'd1;
    localparam logic [2:0] c_ST_LEN     = 3'd2;
    localparam logic [2:0] c_ST_PAYLOAD = 3'd3;
    localparam logic [2:0] c_ST_CSUM    = 3'd4;

    logic [2:0]  r_state_q,     w_state_d;
    logic [7:0]  r_tx_data_q,   w_tx_data_d;
    logic        r_tx_valid_q,  w_tx_valid_d;
    logic [7:0]  r_csum_q,      w_csum_d;
    logic [6:0]  r_words_q,     w_words_d;
    logic [1:0]  r_byte_idx_q,  w_byte_idx_d;
    logic [23:0] r_shift_q,     w_shift_d;   // bytes of the current word not yet on TX_Data
    logic [15:0] r_pkt_count_q, w_pkt_count_d;

    logic w_tx_hs;
    logic w_rx_hs;
    logic w_last_byte;

    assign w_tx_hs     = r_tx_valid_q && TX_Ready;
    assign w_last_byte = (r_byte_idx_q == 2'd3);
    assign w_rx_hs     = RX_Valid && RX_Ready;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state_q     <= c_ST_IDLE;
            r_tx_data_q   <= 8'h00;
            r_tx_valid_q  <= 1'b0;
            r_csum_q      <= 8'h00;
            r_words_q     <= 7'd0;
            r_byte_idx_q  <= 2'd0;
            r_shift_q     <= 24'h0;
            r_pkt_count_q <= 16'h0000;
        end else begin
            r_state_q     <= w_state_d;
            r_tx_data_q   <= w_tx_data_d;
            r_tx_valid_q  <= w_tx_valid_d;
            r_csum_q      <= w_csum_d;
            r_words_q     <= w_words_d;
            r_byte_idx_q  <= w_byte_idx_d;
            r_shift_q     <= w_shift_d;
            r_pkt_count_q <= w_pkt_count_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d     = r_state_q;
        w_tx_data_d   = r_tx_data_q;
        w_tx_valid_d  = r_tx_valid_q;
        w_csum_d      = r_csum_q;
        w_words_d     = r_words_q;
        w_byte_idx_d  = r_byte_idx_q;
        w_shift_d     = r_shift_q;
        w_pkt_count_d = r_pkt_count_q;

        case (r_state_q)
            c_ST_IDLE: begin
                // The word that triggered the packet stays in the FIFO.
                if (RX_Valid) begin
                    w_tx_data_d  = SYNC;
                    w_tx_valid_d = 1'b1;
                    w_state_d    = c_ST_HDR;
                end
            end
            c_ST_HDR: begin
                if (w_tx_hs) begin
                    w_tx_data_d = c_LEN;
                    w_csum_d    = c_LEN;
                    w_words_d   = 7'd0;
                    w_state_d   = c_ST_LEN;
                end
            end
            c_ST_LEN: begin
                // If no word is taken on this edge the payload starts empty.
                if (w_tx_hs) begin
                    w_tx_valid_d = 1'b0;
                    w_words_d    = 7'd0;
                    w_state_d    = c_ST_PAYLOAD;
                end
            end
            c_ST_PAYLOAD: begin
                if (w_tx_hs) begin
                    w_csum_d = r_csum_q ^ r_tx_data_q;
                    if (!w_last_byte) begin
                        w_byte_idx_d = r_byte_idx_q + 2'd1;
                        w_tx_data_d  = r_shift_q[7:0];
                        w_shift_d    = {8'h00, r_shift_q[23:8]};
                    end else if (r_words_q == c_WORDS) begin
                        // Checksum must include the byte leaving on this edge.
                        w_tx_data_d = r_csum_q ^ r_tx_data_q;
                        w_state_d   = c_ST_CSUM;
                    end else begin
                        // Word drained; a same-edge word load below overrides this.
                        w_tx_valid_d = 1'b0;
                    end
                end
            end
            c_ST_CSUM: begin
                if (w_tx_hs) begin
                    w_tx_valid_d  = 1'b0;
                    w_pkt_count_d = r_pkt_count_q + 16'd1;
                    w_state_d     = c_ST_IDLE;
                end
            end
            default: begin
                w_state_d    = c_ST_IDLE;
                w_tx_valid_d = 1'b0;
            end
        endcase

        // Word load: RX_Ready is only raised where TX_Data is free on this edge.
        if (w_rx_hs) begin
            w_tx_data_d  = RX_Data[7:0];
            w_shift_d    = RX_Data[31:8];
            w_tx_valid_d = 1'b1;
            w_byte_idx_d = 2'd0;
            w_words_d    = r_words_q + 7'd1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        RX_Ready = 1'b0;
        case (r_state_q)
            // Taking the first word as LEN leaves avoids a bubble after LEN.
            c_ST_LEN:     RX_Ready = w_tx_hs;
            // In PAYLOAD, TX_Valid low means the shift register is empty.
            c_ST_PAYLOAD: RX_Ready = (r_words_q < c_WORDS) &&
                                     (!r_tx_valid_q || (w_last_byte && w_tx_hs));
            default:      RX_Ready = 1'b0;
        endcase
        busy = (r_state_q != c_ST_IDLE);
    end

    assign TX_Data   = r_tx_data_q;
    assign TX_Valid  = r_tx_valid_q;
    assign pkt_count = r_pkt_count_q;

endmodule
`default_nettype wire
